hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline. It complements the forwarding unit by handling every hazard that bypass muxes cannot resolve.
- Handled hazards: load-use RAW, any RAW when forwarding is disabled, taken-branch flush, multi-cycle data-memory wait.
- Sits beside the ID stage; drives stall/flush/bubble controls of PC and all pipeline registers.

Parameters:
REG_ADDR_W, `REG_FILE_ADDR_LEN (5), register-file address width
MEM_TIMEOUT, 64, max MEM_WAIT cycles before error flag; must be >= 2
TO_CNT_W, 7, timeout counter width; must satisfy 2^TO_CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
forward_EN  in  1  1 = forwarding unit active
src1_ID  in  REG_ADDR_W  ID-stage source 1
src2_ID  in  REG_ADDR_W  ID-stage source 2
two_src_ID  in  1  ID instruction reads src2 (R-type, store, branch)
dest_EXE  in  REG_ADDR_W  EXE destination
WB_EN_EXE  in  1  EXE writes back
MEM_R_EN_EXE  in  1  EXE instruction is a load
dest_MEM  in  REG_ADDR_W  MEM destination
WB_EN_MEM  in  1  MEM writes back
branch_taken_EXE  in  1  branch resolved taken in EXE
mem_req  in  1  MEM stage issues a data-memory access
mem_ready  in  1  data memory completes access this cycle
pc_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  clear IF/ID to NOP
ID_EXE_stall  out  1  hold ID/EXE
ID_EXE_bubble  out  1  load NOP into ID/EXE
EXE_MEM_stall  out  1  hold EXE/MEM
MEM_WB_bubble  out  1  load NOP into MEM/WB
mem_timeout_err  out  1  sticky memory timeout flag

Behaviour:
- Outputs are combinational from inputs plus registered state; no output latency.
- Reset (rst=0, async): state=RUN, timeout counter=0, mem_timeout_err=0. All stall/flush/bubble outputs are 0 while in reset.
- RAW compare: hit_X(s) = WB_EN_X && dest_X==s && dest_X!=0. src2 is considered only when two_src_ID=1.
- data_hz:
  - forward_EN=1: data_hz = MEM_R_EN_EXE && hit_EXE.
  - forward_EN=0: data_hz = hit_EXE || hit_MEM.
- freeze = mem_req && !mem_ready.
- States: RUN, MEM_WAIT, FLUSH.
- Priority each cycle: freeze > branch > data_hz.
  - freeze: pc_stall, IF_ID_stall, ID_EXE_stall, EXE_MEM_stall and MEM_WB_bubble = 1; all others 0. A branch or data hazard in the same cycle is ignored; it re-evaluates after the freeze.
  - branch_taken_EXE, no freeze: IF_ID_flush=1, ID_EXE_bubble=1; next state FLUSH.
  - data_hz, no freeze, state!=FLUSH: pc_stall=1, IF_ID_stall=1, ID_EXE_bubble=1.
- Transitions:
  - RUN -> MEM_WAIT on freeze.
  - MEM_WAIT -> RUN in the cycle mem_ready=1. Stall outputs drop combinationally in that same cycle.
  - MEM_WAIT -> FLUSH if mem_ready=1 and branch_taken_EXE=1 in the same cycle.
  - FLUSH -> RUN unconditionally after 1 cycle. In FLUSH, data_hz is masked because ID holds a flushed NOP; freeze and branch are still honoured.
- Timeout counter: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle, saturates. When count reaches MEM_TIMEOUT-1 with mem_ready=0, mem_timeout_err is set. The flag is cleared only by reset; the pipeline keeps waiting.
- Back-to-back data hazards stall each cycle until the hazard clears; a load-use hazard stalls exactly 1 cycle when forward_EN=1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs stall_cycles (increments on any cycle with pc_stall=1) and flush_count (increments per taken-branch flush). Both are wrap-around counters cleared by reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- defines.v: `REG_FILE_ADDR_LEN; state encodings `HZ_RUN=2'd0, `HZ_MEM_WAIT=2'd1, `HZ_FLUSH=2'd2; `HZ_STATE_LEN=2.
- Sub-module hazard_raw_cmp: one RAW comparator (wb_en, dest, src, src_valid -> hit). Instantiated 4 times.

Test Plan:
- Load-use: forward_EN=1, MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=5, src1_ID=5 -> pc_stall=IF_ID_stall=ID_EXE_bubble=1 for exactly 1 cycle; with MEM_R_EN_EXE=0 -> no stall.
- No forwarding: forward_EN=0, WB_EN_MEM=1, dest_MEM=7, src2_ID=7, two_src_ID=1 -> stall; repeat with two_src_ID=0 -> no stall; dest=0 -> never stall.
- Branch: branch_taken_EXE=1 while data_hz=1 -> IF_ID_flush=ID_EXE_bubble=1, pc_stall=0; next cycle (FLUSH) the data hazard is masked, state returns to RUN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all four stalls plus MEM_WB_bubble high for 3 cycles, deasserted in the ready cycle; concurrent branch is deferred.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err=1 after the 4th wait cycle and stays 1 after mem_ready=1; async rst=0 mid-wait -> immediate RUN, all outputs 0.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 branch -> stall_cycles=2, flush_count=1.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared widths and controller state encoding for the hazard stall unit.
package hazard_stall_unit_pkg;

    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int HZ_STATE_LEN      = 2;

    typedef enum logic [HZ_STATE_LEN-1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_stall_unit_raw_cmp.sv
// Single read-after-write comparator: producer (wb_en, dest) against one ID source.
module hazard_raw_cmp #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] dest_i,
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  src_valid_i,
    output logic                  hit_o
);

    // Register 0 is hardwired to zero, so writing it never creates a dependency.
    assign hit_o = src_valid_i && wb_en_i && (dest_i == src_i) && (dest_i != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, no-forwarding RAW,
// taken-branch flush and data-memory wait. `HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_FILE_ADDR_LEN,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_CNT_W    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_EN,
    input  logic [REG_ADDR_W-1:0] src1_ID,
    input  logic [REG_ADDR_W-1:0] src2_ID,
    input  logic                  two_src_ID,
    input  logic [REG_ADDR_W-1:0] dest_EXE,
    input  logic                  WB_EN_EXE,
    input  logic                  MEM_R_EN_EXE,
    input  logic [REG_ADDR_W-1:0] dest_MEM,
    input  logic                  WB_EN_MEM,
    input  logic                  branch_taken_EXE,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  IF_ID_stall,
    output logic                  IF_ID_flush,
    output logic                  ID_EXE_stall,
    output logic                  ID_EXE_bubble,
    output logic                  EXE_MEM_stall,
    output logic                  MEM_WB_bubble,
    output logic                  mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    hz_state_e           state_q, state_d;
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                err_q, err_d;
    logic                hit_exe_s1, hit_exe_s2, hit_mem_s1, hit_mem_s2;
    logic                hit_exe, hit_mem, data_hz, freeze, flush_go;

    hazard_raw_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_exe_s1 (
        .wb_en_i(WB_EN_EXE), .dest_i(dest_EXE), .src_i(src1_ID), .src_valid_i(1'b1), .hit_o(hit_exe_s1)
    );
    hazard_raw_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_exe_s2 (
        .wb_en_i(WB_EN_EXE), .dest_i(dest_EXE), .src_i(src2_ID), .src_valid_i(two_src_ID), .hit_o(hit_exe_s2)
    );
    hazard_raw_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem_s1 (
        .wb_en_i(WB_EN_MEM), .dest_i(dest_MEM), .src_i(src1_ID), .src_valid_i(1'b1), .hit_o(hit_mem_s1)
    );
    hazard_raw_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem_s2 (
        .wb_en_i(WB_EN_MEM), .dest_i(dest_MEM), .src_i(src2_ID), .src_valid_i(two_src_ID), .hit_o(hit_mem_s2)
    );

    assign hit_exe  = hit_exe_s1 || hit_exe_s2;
    assign hit_mem  = hit_mem_s1 || hit_mem_s2;
    // With bypassing only a load in EXE is too late to forward; without it every RAW stalls.
    assign data_hz  = forward_EN ? (MEM_R_EN_EXE && hit_exe) : (hit_exe || hit_mem);
    assign freeze   = mem_req && !mem_ready;
    assign flush_go = branch_taken_EXE && !freeze;

    always_comb begin
        state_d  = HZ_RUN;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (freeze) begin
            state_d = HZ_MEM_WAIT;
            if (state_q != HZ_MEM_WAIT) begin
                to_cnt_d = '0;
            end else if (to_cnt_q != '1) begin
                to_cnt_d = to_cnt_q + TO_CNT_W'(1);
            end
            // The entry cycle is the first wait cycle, so hitting MEM_TIMEOUT-1 means MEM_TIMEOUT cycles waited.
            if ((state_q == HZ_MEM_WAIT) && (to_cnt_d == TO_CNT_W'(MEM_TIMEOUT - 1))) begin
                err_d = 1'b1;
            end
        end else if (flush_go) begin
            state_d = HZ_FLUSH;
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EXE_stall  = 1'b0;
        ID_EXE_bubble = 1'b0;
        EXE_MEM_stall = 1'b0;
        MEM_WB_bubble = 1'b0;
        if (rst) begin
            if (freeze) begin
                pc_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                ID_EXE_stall  = 1'b1;
                EXE_MEM_stall = 1'b1;
                MEM_WB_bubble = 1'b1;
            end else if (branch_taken_EXE) begin
                IF_ID_flush   = 1'b1;
                ID_EXE_bubble = 1'b1;
            end else if (data_hz && (state_q != HZ_FLUSH)) begin
                // ID holds a flushed NOP in FLUSH, so any apparent hazard there is stale.
                pc_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                ID_EXE_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= HZ_RUN;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (pc_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (flush_go) flush_count_q  <= flush_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized
// cycles checked against a cycle-level behavioural model (MEM_TIMEOUT=4).
module tb_hazard_stall_unit;

    localparam int RW = 5;
    localparam int MT = 4;
    // {pc_stall, IF_ID_stall, IF_ID_flush, ID_EXE_stall, ID_EXE_bubble, EXE_MEM_stall, MEM_WB_bubble}
    localparam logic [6:0] EXP_NONE   = 7'b0000000;
    localparam logic [6:0] EXP_FREEZE = 7'b1101011;
    localparam logic [6:0] EXP_FLUSH  = 7'b0010100;
    localparam logic [6:0] EXP_STALL  = 7'b1100100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, forward_EN, two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
    logic          branch_taken_EXE, mem_req, mem_ready;
    logic [RW-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
    logic          pc_stall, IF_ID_stall, IF_ID_flush, ID_EXE_stall, ID_EXE_bubble;
    logic          EXE_MEM_stall, MEM_WB_bubble, mem_timeout_err;
    logic [6:0]    outs;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, flush_count;
`endif

    assign outs = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EXE_stall, ID_EXE_bubble, EXE_MEM_stall, MEM_WB_bubble};

    hazard_stall_unit #(.REG_ADDR_W(RW), .MEM_TIMEOUT(MT), .TO_CNT_W(3)) dut (
        .clk(clk), .rst(rst), .forward_EN(forward_EN),
        .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
        .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
        .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .branch_taken_EXE(branch_taken_EXE),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EXE_stall(ID_EXE_stall), .ID_EXE_bubble(ID_EXE_bubble),
        .EXE_MEM_stall(EXE_MEM_stall), .MEM_WB_bubble(MEM_WB_bubble),
        .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    // Model state: previous cycle flushed ID, length of the current memory-wait run, sticky error.
    logic flush_prev_m = 1'b0;
    int   run_m        = 0;
    logic err_m        = 1'b0;

    function automatic logic [6:0] model_out();
        logic he, hm, dh;
        he = WB_EN_EXE && (dest_EXE != 0) && ((dest_EXE == src1_ID) || (two_src_ID && dest_EXE == src2_ID));
        hm = WB_EN_MEM && (dest_MEM != 0) && ((dest_MEM == src1_ID) || (two_src_ID && dest_MEM == src2_ID));
        dh = forward_EN ? (MEM_R_EN_EXE && he) : (he || hm);
        if (!rst) return EXP_NONE;
        if (mem_req && !mem_ready) return EXP_FREEZE;
        if (branch_taken_EXE) return EXP_FLUSH;
        if (dh && !flush_prev_m) return EXP_STALL;
        return EXP_NONE;
    endfunction

    task automatic tick();
        logic fz, fl;
        fz = mem_req && !mem_ready;
        fl = branch_taken_EXE && !fz;
        @(posedge clk);
        if (rst) begin
            flush_prev_m = fl;
            run_m = fz ? run_m + 1 : 0;
            if (run_m >= MT) err_m = 1'b1;
        end else begin
            flush_prev_m = 1'b0;
            run_m = 0;
            err_m = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        forward_EN = 1'b1; two_src_ID = 1'b0; WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0;
        WB_EN_MEM = 1'b0; branch_taken_EXE = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
    endtask

    task automatic settle();
        idle();
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        forward_EN = 1'b0; WB_EN_EXE = 1'b1; dest_EXE = 5'd4; src1_ID = 5'd4;
        branch_taken_EXE = 1'b1; mem_req = 1'b1;
        #2;
        n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", outs, EXP_NONE); end
        n_checks++;
        if (mem_timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", mem_timeout_err); end
        tick();
        tick();
        rst = 1'b1;
        settle();
    endtask

    task automatic test_load_use();
        idle();
        MEM_R_EN_EXE = 1'b1; WB_EN_EXE = 1'b1; dest_EXE = 5'd5; src1_ID = 5'd5;
        @(negedge clk); n_checks++;
        if (outs !== EXP_STALL) begin n_fail++; $display("FAIL load_use_stall: got %b want %b", outs, EXP_STALL); end
        tick();
        // Load moved to MEM behind the bubble; forwarding covers it now.
        MEM_R_EN_EXE = 1'b0; WB_EN_EXE = 1'b0; dest_EXE = '0; WB_EN_MEM = 1'b1; dest_MEM = 5'd5;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL load_use_one_cycle: got %b want %b", outs, EXP_NONE); end
        tick();
        idle();
        WB_EN_EXE = 1'b1; dest_EXE = 5'd5; src1_ID = 5'd5;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL alu_forwarded: got %b want %b", outs, EXP_NONE); end
        tick();
        MEM_R_EN_EXE = 1'b1; src1_ID = 5'd1; src2_ID = 5'd5; two_src_ID = 1'b0;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL load_src2_unused: got %b want %b", outs, EXP_NONE); end
        settle();
    endtask

    task automatic test_no_forward();
        idle();
        forward_EN = 1'b0; WB_EN_MEM = 1'b1; dest_MEM = 5'd7; src2_ID = 5'd7; two_src_ID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); n_checks++;
            if (outs !== EXP_STALL) begin n_fail++; $display("FAIL nofwd_stall_%0d: got %b want %b", k, outs, EXP_STALL); end
            tick();
        end
        two_src_ID = 1'b0;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL nofwd_one_src: got %b want %b", outs, EXP_NONE); end
        tick();
        dest_MEM = '0; src1_ID = '0; src2_ID = '0; two_src_ID = 1'b1; WB_EN_EXE = 1'b1; dest_EXE = '0;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL nofwd_reg0: got %b want %b", outs, EXP_NONE); end
        settle();
    endtask

    task automatic test_branch();
        idle();
        forward_EN = 1'b0; WB_EN_EXE = 1'b1; dest_EXE = 5'd3; src1_ID = 5'd3; branch_taken_EXE = 1'b1;
        @(negedge clk); n_checks++;
        if (outs !== EXP_FLUSH) begin n_fail++; $display("FAIL branch_flush: got %b want %b", outs, EXP_FLUSH); end
        tick();
        branch_taken_EXE = 1'b0;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL branch_mask: got %b want %b", outs, EXP_NONE); end
        tick();
        @(negedge clk); n_checks++;
        if (outs !== EXP_STALL) begin n_fail++; $display("FAIL branch_back_to_run: got %b want %b", outs, EXP_STALL); end
        settle();
    endtask

    task automatic test_mem_wait();
        idle();
        forward_EN = 1'b0; WB_EN_EXE = 1'b1; dest_EXE = 5'd9; src1_ID = 5'd9;
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken_EXE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); n_checks++;
            if (outs !== EXP_FREEZE) begin n_fail++; $display("FAIL mem_freeze_%0d: got %b want %b", k, outs, EXP_FREEZE); end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk); n_checks++;
        if (outs !== EXP_FLUSH) begin n_fail++; $display("FAIL mem_ready_branch: got %b want %b", outs, EXP_FLUSH); end
        tick();
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken_EXE = 1'b0;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE) begin n_fail++; $display("FAIL mem_then_flush_mask: got %b want %b", outs, EXP_NONE); end
        settle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            forward_EN       = 1'($urandom_range(0, 1));
            two_src_ID       = 1'($urandom_range(0, 1));
            WB_EN_EXE        = 1'($urandom_range(0, 1));
            MEM_R_EN_EXE     = 1'($urandom_range(0, 1));
            WB_EN_MEM        = 1'($urandom_range(0, 1));
            branch_taken_EXE = ($urandom_range(0, 4) == 0);
            mem_req          = ($urandom_range(0, 3) == 0);
            mem_ready        = 1'($urandom_range(0, 1));
            src1_ID          = RW'($urandom_range(0, 3));
            src2_ID          = RW'($urandom_range(0, 3));
            dest_EXE         = RW'($urandom_range(0, 3));
            dest_MEM         = RW'($urandom_range(0, 3));
            @(negedge clk); n_checks++;
            if (outs !== model_out()) begin
                n_fail++; $display("FAIL random_outs cycle %0d: got %b want %b", c, outs, model_out());
            end
            n_checks++;
            if (mem_timeout_err !== err_m) begin
                n_fail++; $display("FAIL random_err cycle %0d: got %b want %b", c, mem_timeout_err, err_m);
            end
            tick();
        end
        settle();
    endtask

    task automatic test_timeout();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); n_checks++;
            if (outs !== EXP_FREEZE || mem_timeout_err !== (k > MT)) begin
                n_fail++; $display("FAIL timeout_wait_%0d: outs %b err %b want %b err %b", k, outs, mem_timeout_err, EXP_FREEZE, (k > MT));
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE || mem_timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_ready: outs %b err %b want %b err 1", outs, mem_timeout_err, EXP_NONE);
        end
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1; n_checks++;
        if (outs !== EXP_NONE || mem_timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_async_rst: outs %b err %b want %b err 0", outs, mem_timeout_err, EXP_NONE);
        end
        tick();
        rst = 1'b1;
        idle();
        @(negedge clk); n_checks++;
        if (outs !== EXP_NONE || mem_timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after_rst: outs %b err %b want %b err 0", outs, mem_timeout_err, EXP_NONE);
        end
        settle();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            MEM_R_EN_EXE = 1'b1; WB_EN_EXE = 1'b1; dest_EXE = 5'd5; src1_ID = 5'd5;
            tick();
            idle();
            tick();
        end
        branch_taken_EXE = 1'b1;
        tick();
        idle();
        tick();
        @(negedge clk); n_checks++;
        if (stall_cycles !== 32'd2 || flush_count !== 32'd1) begin
            n_fail++; $display("FAIL perf_counters: stall %0d flush %0d want 2 and 1", stall_cycles, flush_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_forward();
        test_branch();
        test_mem_wait();
        test_random();
        test_timeout();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
